// File: rtl/mojo_spi_uart_bridge_if.sv
`timescale 1ns/1ps
// Board-pin bundle for the SPI/UART bridge: SPI slave pins, UART pins and LEDs.
// Latency: none, wires only.
// Backpressure: none; pins are sampled/driven continuously.
// Ports: sclk/cs/mosi/miso (SPI, mode 0), uart_rx/uart_tx (8N1), led[7:0].
interface mojo_spi_uart_bridge_if;
    logic [7:0] led;
    logic       uart_rx;
    logic       uart_tx;
    logic       mosi;
    logic       miso;
    logic       sclk;
    logic       cs;

    // slave: the bridge itself
    modport slave (
        input  uart_rx, mosi, sclk, cs,
        output led, uart_tx, miso
    );

    // master: the host / board environment driving the bridge
    modport master (
        output uart_rx, mosi, sclk, cs,
        input  led, uart_tx, miso
    );
endinterface

// File: rtl/mojo_spi_uart_bridge.sv
`timescale 1ns/1ps
// SPI slave -> LEDs + UART tx; UART rx -> holding byte returned on MISO next SPI frame.
// Latency: led updates SYNC_STAGES+1 clks after raw 8th sclk rise; UART frame starts 1 clk later.
// Backpressure: none; an SPI byte arriving while the UART transmitter is busy is not sent.
// Ports: clk, rst_n (synchronous, active-high despite the name), bus (slave modport).
module mojo_spi_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mojo_spi_uart_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    // input synchronisers, newest sample in bit 0
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] rx_sync_q,   rx_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q,   cs_prev_d;
    logic rx_prev_q,   rx_prev_d;

    // SPI receive / transmit
    logic [7:0] spi_rx_shift_q, spi_rx_shift_d;
    logic [2:0] spi_rx_cnt_q,   spi_rx_cnt_d;
    logic [7:0] led_q,          led_d;
    logic       rx_valid_q,     rx_valid_d;
    logic [7:0] spi_tx_shift_q, spi_tx_shift_d;
    logic [2:0] spi_tx_cnt_q,   spi_tx_cnt_d;

    // UART transmitter
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]       tx_idx_q,   tx_idx_d;
    logic [7:0]       tx_byte_q,  tx_byte_d;
    logic             tx_line_q,  tx_line_d;

    // UART receiver
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]       rx_idx_q,   rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       hold_q,     hold_d;

    logic sclk_s, cs_s, mosi_s, rx_s;
    logic sclk_rise, sclk_fall, cs_fall, rx_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign rx_s      = rx_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign rx_fall   = ~rx_s & rx_prev_q;

    assign bus.led     = led_q;
    assign bus.uart_tx = tx_line_q;
    assign bus.miso    = cs_s ? 1'b0 : spi_tx_shift_q[7];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        rx_sync_d   = {rx_sync_q[SYNC_STAGES-2:0],   bus.uart_rx};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        rx_prev_d   = rx_s;

        // SPI receive: holding the count at zero while deselected discards partial bytes
        spi_rx_shift_d = spi_rx_shift_q;
        spi_rx_cnt_d   = spi_rx_cnt_q;
        led_d          = led_q;
        rx_valid_d     = 1'b0;
        if (cs_s || cs_fall) begin
            spi_rx_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            spi_rx_shift_d = {spi_rx_shift_q[6:0], mosi_s};
            if (spi_rx_cnt_q == 3'd7) begin
                led_d        = spi_rx_shift_d;
                rx_valid_d   = 1'b1;
                spi_rx_cnt_d = 3'd0;
            end else begin
                spi_rx_cnt_d = spi_rx_cnt_q + 3'd1;
            end
        end

        // SPI transmit: shift on the falling edge so the host samples on the rising edge
        spi_tx_shift_d = spi_tx_shift_q;
        spi_tx_cnt_d   = spi_tx_cnt_q;
        if (cs_fall) begin
            spi_tx_shift_d = hold_q;
            spi_tx_cnt_d   = 3'd0;
        end else if (!cs_s && sclk_fall) begin
            if (spi_tx_cnt_q == 3'd7) begin
                spi_tx_shift_d = hold_q;
                spi_tx_cnt_d   = 3'd0;
            end else begin
                spi_tx_shift_d = {spi_tx_shift_q[6:0], 1'b0};
                spi_tx_cnt_d   = spi_tx_cnt_q + 3'd1;
            end
        end

        // UART transmitter
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (rx_valid_q) begin
                    tx_byte_d  = led_q;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
        endcase

        // line level follows the next state so the output is a clean flop with no extra lag
        case (tx_state_d)
            ST_START: tx_line_d = 1'b0;
            ST_DATA:  tx_line_d = tx_byte_d[tx_idx_d];
            default:  tx_line_d = 1'b1;
        endcase

        // UART receiver: recheck start at mid-bit, then sample every bit period
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        hold_d     = hold_q;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == BIT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = 3'd0;
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_s) begin
                        hold_d = rx_shift_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sclk_sync_q    <= '0;
            cs_sync_q      <= '1;
            mosi_sync_q    <= '0;
            rx_sync_q      <= '1;
            sclk_prev_q    <= 1'b0;
            cs_prev_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            spi_rx_shift_q <= 8'h00;
            spi_rx_cnt_q   <= 3'd0;
            led_q          <= 8'h00;
            rx_valid_q     <= 1'b0;
            spi_tx_shift_q <= 8'h00;
            spi_tx_cnt_q   <= 3'd0;
            tx_state_q     <= ST_IDLE;
            tx_cnt_q       <= '0;
            tx_idx_q       <= 3'd0;
            tx_byte_q      <= 8'h00;
            tx_line_q      <= 1'b1;
            rx_state_q     <= ST_IDLE;
            rx_cnt_q       <= '0;
            rx_idx_q       <= 3'd0;
            rx_shift_q     <= 8'h00;
            hold_q         <= 8'h00;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            cs_sync_q      <= cs_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            rx_sync_q      <= rx_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            cs_prev_q      <= cs_prev_d;
            rx_prev_q      <= rx_prev_d;
            spi_rx_shift_q <= spi_rx_shift_d;
            spi_rx_cnt_q   <= spi_rx_cnt_d;
            led_q          <= led_d;
            rx_valid_q     <= rx_valid_d;
            spi_tx_shift_q <= spi_tx_shift_d;
            spi_tx_cnt_q   <= spi_tx_cnt_d;
            tx_state_q     <= tx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_idx_q       <= tx_idx_d;
            tx_byte_q      <= tx_byte_d;
            tx_line_q      <= tx_line_d;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_idx_q       <= rx_idx_d;
            rx_shift_q     <= rx_shift_d;
            hold_q         <= hold_d;
        end
    end
endmodule

// File: tb/tb_mojo_spi_uart_bridge.sv
`timescale 1ns/1ps
// Directed bench for mojo_spi_uart_bridge: SPI bytes to LEDs/UART, loopback return on MISO.
// 16 clks per UART bit so a three-byte SPI burst fits inside one UART frame.
// SPI edges are kept on odd ns offsets from the 20 ns clock so they never coincide with clk edges.
module tb_mojo_spi_uart_bridge;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic loopback;
    logic rx_drv;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   tx_falls = 0;
    logic [7:0] uart_bytes[$];
    logic       uart_stops[$];
    logic [7:0] mi, la, led_before;
    int         falls_before;
    logic [7:0] bad_byte;

    mojo_spi_uart_bridge_if bus();
    assign bus.uart_rx = loopback ? bus.uart_tx : rx_drv;

    mojo_spi_uart_bridge #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    always @(negedge bus.uart_tx) tx_falls++;

    // UART line decoder: samples each bit at its centre, records data byte and stop level
    initial begin : uart_mon
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge bus.uart_tx);
            repeat (CPB/2) @(posedge clk);
            #1;
            if (bus.uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = bus.uart_tx;
                end
                repeat (CPB) @(posedge clk);
                #1;
                sb = bus.uart_tx;
                uart_bytes.push_back(b);
                uart_stops.push_back(sb);
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one full 8-bit SPI frame; returns the MISO byte sampled at each sclk rise and
    // the LED value 4 clks after the 8th rise
    task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi_o, output logic [7:0] led_o);
        bus.cs   = 1'b0;
        bus.mosi = mo[7];
        #124;
        for (int i = 7; i >= 0; i--) begin
            mi_o[i]  = bus.miso;
            bus.sclk = 1'b1;
            #62;
            bus.sclk = 1'b0;
            if (i > 0) begin
                bus.mosi = mo[i-1];
                #62;
            end else begin
                #18;
                led_o = bus.led;
                #44;
            end
        end
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (uart_bytes.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("uart_frame_seen", 8'(uart_bytes.size() >= n), 8'd1);
    endtask

    function automatic logic [7:0] frame_byte(input int k);
        return (uart_bytes.size() > k) ? uart_bytes[k] : 8'hxx;
    endfunction

    function automatic logic [7:0] frame_stop(input int k);
        return (uart_stops.size() > k) ? {7'd0, uart_stops[k]} : 8'hxx;
    endfunction

    initial begin
        // 1: reset
        rst_n    = 1'b1;
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        loopback = 1'b1;
        rx_drv   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        check("rst_led", bus.led, 8'h00);
        check("rst_uart_tx", 8'(bus.uart_tx), 8'd1);
        check("rst_miso", 8'(bus.miso), 8'd0);
        repeat (4) @(posedge clk);
        #1;

        // 2: single byte 0xAA -> LEDs and UART
        spi_xfer(8'hAA, mi, la);
        check("aa_led_4clk", la, 8'hAA);
        check("aa_miso_empty_hold", mi, 8'h00);
        wait_frames(1);
        check("aa_uart_byte", frame_byte(0), 8'hAA);
        check("aa_uart_stop", frame_stop(0), 8'd1);
        repeat (10) @(posedge clk);
        #1;

        // 3: back-to-back frames; only the first reaches the UART
        spi_xfer(8'h33, mi, la);
        check("b2b_led_33", la, 8'h33);
        check("b2b_miso_loop_aa", mi, 8'hAA);
        #100;
        spi_xfer(8'hFF, mi, la);
        check("b2b_led_ff", la, 8'hFF);
        check("b2b_miso_hold_aa", mi, 8'hAA);
        #100;
        spi_xfer(8'h00, mi, la);
        check("b2b_led_00", la, 8'h00);
        wait_frames(2);
        check("b2b_uart_byte", frame_byte(1), 8'h33);
        repeat (400) @(posedge clk);
        #1;
        check("b2b_dropped", 8'(uart_bytes.size()), 8'd2);

        // 4: sclk activity with cs high is ignored
        led_before   = bus.led;
        falls_before = tx_falls;
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = i[0] ? 1'b1 : 1'b0;
            bus.sclk = 1'b1;
            #62;
            bus.sclk = 1'b0;
            #62;
        end
        repeat (20) @(posedge clk);
        #1;
        check("cs_high_led", bus.led, led_before);
        check("cs_high_no_uart", 8'(tx_falls - falls_before), 8'd0);

        // 5: loopback byte returned on MISO, then glitch and framing error leave hold alone
        spi_xfer(8'hC3, mi, la);
        check("loop_miso_33", mi, 8'h33);
        check("loop_led_c3", la, 8'hC3);
        wait_frames(3);
        check("loop_uart_c3", frame_byte(2), 8'hC3);
        repeat (10) @(posedge clk);
        #1;
        loopback = 1'b0;
        rx_drv   = 1'b0;
        #40;
        rx_drv   = 1'b1;
        repeat (2*CPB) @(posedge clk);
        #1;
        bad_byte = 8'h5A;
        rx_drv   = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_drv = bad_byte[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_drv = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (4*CPB) @(posedge clk);
        #1;
        spi_xfer(8'h00, mi, la);
        check("framing_err_hold", mi, 8'hC3);
        wait_frames(4);
        check("uart_byte_00", frame_byte(3), 8'h00);
        repeat (10) @(posedge clk);
        #1;

        // 6: partial frame discarded, then full 0x5A; reset mid UART frame
        bus.cs   = 1'b0;
        bus.mosi = 1'b1;
        #124;
        for (int i = 0; i < 4; i++) begin
            bus.sclk = 1'b1;
            #62;
            bus.sclk = 1'b0;
            #62;
        end
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        #100;
        spi_xfer(8'h5A, mi, la);
        check("partial_then_5a_led", la, 8'h5A);
        check("partial_then_miso", mi, 8'hC3);
        // frame started ~3 clks ago; land inside data bit 2 (a 0 for 0x5A)
        repeat (52) @(posedge clk);
        #1;
        check("tx_mid_frame_low", 8'(bus.uart_tx), 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_uart_tx", 8'(bus.uart_tx), 8'd1);
        check("midrst_led", bus.led, 8'h00);
        check("midrst_miso", 8'(bus.miso), 8'd0);
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
